pwm_capture: RTL and testbench

//  - Measures an incoming PWM waveform and reports period and high time in PWM_Geneator's

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_edge_detect.sv | 82 ++++++++
 rtl/pwm_capture.sv | 131 +++++++++++++
 tb/tb_pwm_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states, counter width,
// default timeout and a saturating increment helper.
package pwm_pkg;

  localparam int PWM_CNT_W = 32;

  localparam logic [PWM_CNT_W-1:0] TIMEOUT_DEF = 32'd2000000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } pwm_state_e;

  function automatic logic [PWM_CNT_W-1:0] sat_inc(
    input logic [PWM_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pwm_edge_detect.sv
// PWM input synchronizer and registered rise/fall strobes.
// PWM_CAPTURE_GLITCH_FILTER_EN adds a FILTER_LEN-sample level filter.
module pwm_edge_detect
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic pwm_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic sample;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
  assign sample = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int RUN_W = $clog2(FILTER_LEN + 1);

  logic [RUN_W-1:0] run_q, run_d;

  // run counts consecutive samples disagreeing with the held level
  always_comb begin
    level_d = level_q;
    run_d   = '0;
    if (sample != level_q) begin
      if (run_q == RUN_W'(FILTER_LEN - 1)) begin
        level_d = sample;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`else
  logic unused_filter_len;

  assign unused_filter_len = (FILTER_LEN != 0);
  assign level_d = sample;
`endif

  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise  = rise_q;
  assign fall  = fall_q;
  assign level = level_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with signal-loss timeout.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to enable the input glitch filter.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic [PWM_CNT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int FILTER_LEN = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 en,
  input  logic                 pwm_in,
  output logic [PWM_CNT_W-1:0] total_dur,
  output logic [PWM_CNT_W-1:0] high_dur,
  output logic                 valid,
  output logic                 timeout,
  output logic                 lost_level
);

  logic rise, fall, level;

  pwm_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_edge (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .pwm_in(pwm_in),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  pwm_state_e state_q, state_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic [PWM_CNT_W-1:0] idle_q, idle_d;
  logic [PWM_CNT_W-1:0] hi_q, hi_d;
  logic [PWM_CNT_W-1:0] tot_q, tot_d;
  logic [PWM_CNT_W-1:0] hd_q, hd_d;
  logic valid_q, valid_d;
  logic to_q, to_d;
  logic ll_q, ll_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = rise ? PWM_CNT_W'(1) : sat_inc(cnt_q);
    idle_d  = '0;
    hi_d    = hi_q;
    tot_d   = tot_q;
    hd_d    = hd_q;
    valid_d = 1'b0;
    to_d    = to_q;
    ll_d    = ll_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            state_d = HIGH;
            to_d    = 1'b0;
          end else begin
            idle_d = sat_inc(idle_q);
            if (idle_q == TIMEOUT_CYCLES) begin
              to_d = 1'b1;
              ll_d = level;
            end
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            hi_d    = cnt_q;
          end else if (cnt_q == TIMEOUT_CYCLES) begin
            state_d = WAIT_RISE;
            to_d    = 1'b1;
            ll_d    = level;
          end
        end
        LOW: begin
          // an edge always beats a coincident timeout
          if (rise) begin
            state_d = HIGH;
            tot_d   = cnt_q - 1'b1;
            hd_d    = hi_q;
            valid_d = 1'b1;
            to_d    = 1'b0;
          end else if (cnt_q == TIMEOUT_CYCLES) begin
            state_d = WAIT_RISE;
            to_d    = 1'b1;
            ll_d    = level;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      hi_q    <= '0;
      tot_q   <= '0;
      hd_q    <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      ll_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      hi_q    <= hi_d;
      tot_q   <= tot_d;
      hd_q    <= hd_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      ll_q    <= ll_d;
    end
  end

  assign total_dur  = tot_q;
  assign high_dur   = hd_q;
  assign valid      = valid_q;
  assign timeout    = to_q;
  assign lost_level = ll_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: drives PWM waves and compares every valid
// strobe (time, period, high time) against a period-level model.
module tb_pwm_capture;

  localparam int SYNC = 2;
  localparam int FLEN = 4;
  localparam logic [31:0] TMO = 32'd100;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT  = SYNC + 2 + FLEN - 1;
  localparam int T1_H = 5;
`else
  localparam int LAT  = SYNC + 2;
  localparam int T1_H = 3;
`endif
  localparam int T1_P = 10;

  typedef struct {
    int p;
    int h;
    int t;
    bit rep;
  } stim_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        en;
  logic        pwm_in;
  logic [31:0] total_dur;
  logic [31:0] high_dur;
  logic        valid;
  logic        timeout;
  logic        lost_level;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  stim_t       stim[$];
  logic [95:0] got[$];

  pwm_capture #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLEN)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .en        (en),
    .pwm_in    (pwm_in),
    .total_dur (total_dur),
    .high_dur  (high_dur),
    .valid     (valid),
    .timeout   (timeout),
    .lost_level(lost_level)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk)
    if (valid === 1'b1)
      got.push_back({32'(cyc), total_dur, high_dur});

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wave(input int p, input int h);
    stim.push_back('{p, h, cyc, 1'b1});
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic rise_only();
    stim.push_back('{0, 0, cyc, 1'b0});
    pwm_in = 1'b1;
    tick(LAT + 2);
  endtask

  task automatic glitch_wave();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    stim.push_back('{50, 20, cyc, 1'b1});
    pwm_in = 1'b1;
    tick(20);
    pwm_in = 1'b0;
    tick(10);
    pwm_in = 1'b1;
    tick(2);
    pwm_in = 1'b0;
    tick(18);
`else
    wave(30, 20);
    wave(20, 2);
`endif
  endtask

  task automatic quiesce();
    pwm_in = 1'b0;
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(3);
    got.delete();
    stim.delete();
  endtask

  // each reportable period appears LAT cycles after the next rise
  task automatic check_reports(input string tag);
    logic [95:0] exp[$];
    for (int i = 0; i + 1 < stim.size(); i++)
      if (stim[i].rep)
        exp.push_back({32'(stim[i+1].t + LAT),
                       32'(stim[i].p - 1),
                       32'(stim[i].h)});
    chk({tag, "_count"}, 96'(got.size()), 96'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(tag, got[i], exp[i]);
  endtask

  initial begin
    int k;
    int p;
    int h;
    Rst_n = 1'b0;
    en = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    @(negedge Clk);
    chk("rst_total", 96'(total_dur), 96'(0));
    chk("rst_high", 96'(high_dur), 96'(0));
    chk("rst_valid", 96'(valid), 96'(0));
    chk("rst_timeout", 96'(timeout), 96'(0));
    chk("rst_lost", 96'(lost_level), 96'(0));
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    tick(2);
    en = 1'b1;
    tick(3);

    for (int i = 0; i < 6; i++) wave(T1_P, T1_H);
    rise_only();
    check_reports("loopback");

    quiesce();
    repeat (20) begin
      p = int'($urandom_range(60, 12));
      h = int'($urandom_range(p - 5, 5));
      wave(p, h);
    end
    rise_only();
    check_reports("random");

    pwm_in = 1'b0;
    en = 1'b0;
    tick(4);
    got.delete();
    stim.delete();
    chk("to_before", 96'(timeout), 96'(0));
    en = 1'b1;
    k = 0;
    while (timeout !== 1'b1 && k < int'(TMO) + SYNC + 2) begin
      @(negedge Clk);
      k++;
    end
    chk("to_stuck_low", 96'(timeout), 96'(1));
    chk("lost_low", 96'(lost_level), 96'(0));
    chk("no_valid_low", 96'(got.size()), 96'(0));
    @(posedge Clk);
    #1;
    wave(T1_P, T1_H);
    chk("to_cleared", 96'(timeout), 96'(0));
    chk("no_valid_first", 96'(got.size()), 96'(0));
    wave(T1_P, T1_H);
    rise_only();
    check_reports("restore");

    got.delete();
    k = 0;
    while (timeout !== 1'b1 && k < int'(TMO) + LAT + 20) begin
      @(negedge Clk);
      k++;
    end
    chk("to_stuck_high", 96'(timeout), 96'(1));
    chk("lost_high", 96'(lost_level), 96'(1));
    chk("no_valid_high", 96'(got.size()), 96'(0));
    chk("hold_total", 96'(total_dur), 96'(T1_P - 1));
    chk("hold_high", 96'(high_dur), 96'(T1_H));

    @(posedge Clk);
    #1 pwm_in = 1'b0;
    tick(3);
    wave(20, 10);
    wave(20, 10);
    pwm_in = 1'b1;
    tick(6);
    chk("pre_rst_total", 96'(total_dur), 96'(19));
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_total", 96'(total_dur), 96'(0));
    chk("mid_rst_high", 96'(high_dur), 96'(0));
    chk("mid_rst_valid", 96'(valid), 96'(0));
    chk("mid_rst_timeout", 96'(timeout), 96'(0));
    chk("mid_rst_lost", 96'(lost_level), 96'(0));
    pwm_in = 1'b0;
    tick(2);
    Rst_n = 1'b1;
    tick(3);
    got.delete();
    stim.delete();
    repeat (3) begin
      p = int'($urandom_range(60, 12));
      h = int'($urandom_range(p - 5, 5));
      wave(p, h);
    end
    rise_only();
    check_reports("post_reset");

    quiesce();
    wave(30, 12);
    wave(30, 12);
    stim.push_back('{30, 12, cyc, 1'b0});
    pwm_in = 1'b1;
    tick(12);
    pwm_in = 1'b0;
    tick(5);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(8);
    repeat (2) begin
      p = int'($urandom_range(60, 12));
      h = int'($urandom_range(p - 5, 5));
      wave(p, h);
    end
    rise_only();
    check_reports("en_drop");

    quiesce();
    glitch_wave();
    glitch_wave();
    rise_only();
    check_reports("glitch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
